iter_muldiv_unit: RTL and testbench
===================================

// Module: iter_muldiv_unit
// PURPOSE
//  Multi-cycle integer multiply/divide unit beside the single-cycle ALU in the EX stage.
//  Executes MUL/IMUL/DIV/IDIV at 8/16/32/64-bit operand size (bmd).
//  Uses a valid/ready handshake on both sides so the pipeline stalls while it works.
//  Produces low/high results, EFLAGS, and a divide-fault indication.
// PARAMETERS
//  W         64  datapath width; must be a multiple of MUL_STEP and >= 64
//  MUL_STEP  4   multiplier bits retired per cycle (radix 2^MUL_STEP); divider retires 1 bit/cycle
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-high reset
//  in_valid       in   1    operation offered
//  in_ready       out  1    unit idle, accepts offer
//  op             in   2    0=MUL (unsigned), 1=IMUL (signed), 2=DIV (unsigned), 3=IDIV (signed)
//  bmd            in   2    operand size: BMD_08/BMD_16/BMD_32/BMD_64
//  s              in   W    multiplicand / dividend
//  t              in   W    multiplier / divisor
//  eflags_as_src  in   W    current EFLAGS, passed through where unmodified
//  out_valid      out  1    result available
//  out_ready      in   1    consumer takes result
//  d_lo           out  W    product low half / quotient
//  d_hi           out  W    product high half / remainder
//  eflags         out  W    resulting EFLAGS
//  eflags_update  out  1    eflags must be written back
//  div_fault      out  1    divide error (#DE) for the held result
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; d_lo=d_hi=eflags=0; eflags_update=0; div_fault=0.
//  FSM: IDLE -(in_valid)-> CALC, or DONE directly on fault.
//    CALC -(iteration counter hits ITER-1)-> DONE.
//    DONE -(out_ready)-> IDLE.
//  in_ready=1 only in IDLE; out_valid=1 only in DONE; a new accept is possible one cycle after handoff.
//  Accept: s, t, op, bmd, eflags_as_src are registered on the edge with in_valid & in_ready.
//    Inputs are ignored at all other times.
//  Operand forming: s and t are truncated to the bmd width.
//    Then sign-extended (IMUL/IDIV) or zero-extended (MUL/DIV) to W.
//  Latency is independent of bmd and data.
//    ITER = W/MUL_STEP for MUL/IMUL; ITER = W for DIV/IDIV.
//    out_valid rises ITER+1 cycles after the accepting edge.
//  Signed operations compute magnitudes and fix up signs in the final CALC cycle.
//    Quotient truncates toward zero; remainder takes the dividend's sign.
//  DIV uses a single-width dividend (s), not rDX:rAX.
//  Results are the bmd-width low bits, zero-extended to W:
//    MUL: d_lo = product[n-1:0], d_hi = product[2n-1:n], where n = bmd width.
//  MUL flags:
//    CF = OF = (d_hi != 0) for MUL; (d_hi != sign-extension of d_lo) for IMUL.
//    SF = msb of d_lo at bmd; ZF = (d_lo == 0); PF = ~^d_lo[7:0]; AF = 0.
//    All other bits come from eflags_as_src; eflags_update = 1.
//  DIV flags: eflags = eflags_as_src; eflags_update = 0.
//  Fault: t == 0 (at bmd width) for DIV/IDIV, or IDIV of the most-negative value by -1.
//    Goes IDLE->DONE in 1 cycle with div_fault=1, d_lo=d_hi=0, eflags=eflags_as_src, eflags_update=0.
//  Backpressure: in DONE, all outputs hold stable until out_ready.
//    out_ready in other states has no effect.
//  Reset mid-operation (CALC or DONE): the next edge returns to reset values; the result is discarded.
//  Reset has priority over all handshakes.
// TESTING (W=64, MUL_STEP=4)
//  MUL bmd=08 s=0x10 t=0x20 -> d_lo=0x00 d_hi=0x02 CF=OF=1 ZF=1; out_valid 17 cycles after accept.
//  IMUL bmd=32 s=0xFFFFFFFF t=5 -> d_lo=0xFFFFFFFB d_hi=0xFFFFFFFF CF=OF=0 SF=1.
//  IDIV bmd=64 s=-7 t=2 -> d_lo=0xFFFFFFFFFFFFFFFD d_hi=0xFFFFFFFFFFFFFFFF; eflags_update=0; latency 65.
//  DIV t=0 and IDIV bmd=08 s=0x80 t=0xFF -> div_fault=1, d_lo=d_hi=0, out_valid 1 cycle after accept.
//  Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored.
//    Then out_ready=1 -> in_ready=1 next cycle.
//  Assert reset mid-CALC -> next cycle out_valid=0, in_ready=1.
//    A following MUL s=3 t=7 -> d_lo=21 d_hi=0.

Source files
------------

// File: rtl/iter_muldiv_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply/divide unit.
interface iter_muldiv_if #(
  parameter int W = 64
) ();
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [1:0]   bmd;
  logic [W-1:0] s;
  logic [W-1:0] t;
  logic [W-1:0] eflags_as_src;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d_lo;
  logic [W-1:0] d_hi;
  logic [W-1:0] eflags;
  logic         eflags_update;
  logic         div_fault;

  modport master (
    output in_valid, op, bmd, s, t, eflags_as_src, out_ready,
    input  in_ready, out_valid, d_lo, d_hi, eflags, eflags_update, div_fault
  );

  modport slave (
    input  in_valid, op, bmd, s, t, eflags_as_src, out_ready,
    output in_ready, out_valid, d_lo, d_hi, eflags, eflags_update, div_fault
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Fixed-latency MUL/IMUL (radix 2^MUL_STEP shift-add) and DIV/IDIV (restoring, 1 bit/cycle)
// on operand magnitudes, with signs restored in the last iteration cycle.
module iter_muldiv_unit #(
  parameter int W        = 64,
  parameter int MUL_STEP = 4
) (
  input logic          clk,
  input logic          reset,
  iter_muldiv_if.slave bus
);
  localparam int CW       = $clog2(W + 1);
  localparam int MUL_ITER = W / MUL_STEP;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d, bmd_q, bmd_d;
  logic [W-1:0]      eflags_src_q, eflags_src_d, a_q, a_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [W-1:0]      d_lo_q, d_lo_d, d_hi_q, d_hi_d, eflags_q, eflags_d;
  logic              eflags_update_q, eflags_update_d, div_fault_q, div_fault_d;

  logic [W-1:0]          s_ext_s, t_ext_s, in_mask_s, mask_s;
  logic                  fault_s, last_s, cf_s;
  logic [MUL_STEP-1:0]   digit_s;
  logic [W+MUL_STEP-1:0] mul_sum_s;
  logic [W:0]            rem_sh_s, rem_sub_s;
  logic [2*W-1:0]        step_s, prod_fix_s, prod_sh_s;
  logic [W-1:0]          mul_lo_s, mul_hi_s, mul_flags_s;
  logic [6:0]            nb_s;

  function automatic logic [W-1:0] size_mask(input logic [1:0] sz);
    logic [W-1:0] m;
    m = '0;
    case (sz)
      2'd0:    m[7:0]  = '1;
      2'd1:    m[15:0] = '1;
      2'd2:    m[31:0] = '1;
      default: m[63:0] = '1;
    endcase
    return m;
  endfunction

  function automatic logic size_msb(input logic [W-1:0] x, input logic [1:0] sz);
    case (sz)
      2'd0:    return x[7];
      2'd1:    return x[15];
      2'd2:    return x[31];
      default: return x[63];
    endcase
  endfunction

  function automatic logic [W-1:0] form_op(input logic [W-1:0] x, input logic [1:0] sz,
                                           input logic sgn);
    return (x & size_mask(sz)) | ((sgn && size_msb(x, sz)) ? ~size_mask(sz) : '0);
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return W'(0) - x;
  endfunction

  function automatic logic even_parity8(input logic [7:0] b);
    return ~^b;
  endfunction

  // Next-state, datapath step, sign fix-up and result formation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    bmd_d           = bmd_q;
    eflags_src_d    = eflags_src_q;
    a_d             = a_q;
    acc_d           = acc_q;
    neg_res_d       = neg_res_q;
    neg_rem_d       = neg_rem_q;
    d_lo_d          = d_lo_q;
    d_hi_d          = d_hi_q;
    eflags_d        = eflags_q;
    eflags_update_d = eflags_update_q;
    div_fault_d     = div_fault_q;

    s_ext_s   = form_op(bus.s, bus.bmd, bus.op[0]);
    t_ext_s   = form_op(bus.t, bus.bmd, bus.op[0]);
    in_mask_s = size_mask(bus.bmd);
    // Signed overflow: most-negative dividend (only the top bit set at bmd) over -1.
    fault_s   = bus.op[1] && ((t_ext_s == '0) ||
                (bus.op[0] && ((bus.s & in_mask_s) == (in_mask_s ^ (in_mask_s >> 1))) &&
                 ((bus.t & in_mask_s) == in_mask_s)));

    digit_s   = acc_q[MUL_STEP-1:0];
    mul_sum_s = {{MUL_STEP{1'b0}}, acc_q[2*W-1:W]} +
                ({{MUL_STEP{1'b0}}, a_q} * {{W{1'b0}}, digit_s});
    rem_sh_s  = {acc_q[2*W-1:W], acc_q[W-1]};
    rem_sub_s = rem_sh_s - {1'b0, a_q};
    step_s    = op_q[1] ? {(rem_sub_s[W] ? rem_sh_s[W-1:0] : rem_sub_s[W-1:0]),
                           acc_q[W-2:0], ~rem_sub_s[W]}
                        : {mul_sum_s, acc_q[W-1:MUL_STEP]};
    last_s    = op_q[1] ? (cnt_q == CW'(W - 1)) : (cnt_q == CW'(MUL_ITER - 1));

    mask_s = size_mask(bmd_q);
    case (bmd_q)
      2'd0:    nb_s = 7'd8;
      2'd1:    nb_s = 7'd16;
      2'd2:    nb_s = 7'd32;
      default: nb_s = 7'd64;
    endcase
    prod_fix_s  = neg_res_q ? ((2*W)'(0) - step_s) : step_s;
    prod_sh_s   = prod_fix_s >> nb_s;
    mul_lo_s    = prod_fix_s[W-1:0] & mask_s;
    mul_hi_s    = prod_sh_s[W-1:0] & mask_s;
    cf_s        = op_q[0] ? (mul_hi_s != (size_msb(mul_lo_s, bmd_q) ? mask_s : '0))
                          : (mul_hi_s != '0);
    mul_flags_s     = eflags_src_q;
    mul_flags_s[0]  = cf_s;
    mul_flags_s[2]  = even_parity8(mul_lo_s[7:0]);
    mul_flags_s[4]  = 1'b0;
    mul_flags_s[6]  = (mul_lo_s == '0);
    mul_flags_s[7]  = size_msb(mul_lo_s, bmd_q);
    mul_flags_s[11] = cf_s;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d         = bus.op;
          bmd_d        = bus.bmd;
          eflags_src_d = bus.eflags_as_src;
          cnt_d        = '0;
          neg_res_d    = bus.op[0] && (s_ext_s[W-1] ^ t_ext_s[W-1]);
          neg_rem_d    = bus.op[0] && s_ext_s[W-1];
          if (bus.op[1]) begin
            a_d   = (bus.op[0] && t_ext_s[W-1]) ? neg_w(t_ext_s) : t_ext_s;
            acc_d = {{W{1'b0}}, ((bus.op[0] && s_ext_s[W-1]) ? neg_w(s_ext_s) : s_ext_s)};
          end else begin
            a_d   = (bus.op[0] && s_ext_s[W-1]) ? neg_w(s_ext_s) : s_ext_s;
            acc_d = {{W{1'b0}}, ((bus.op[0] && t_ext_s[W-1]) ? neg_w(t_ext_s) : t_ext_s)};
          end
          if (fault_s) begin
            state_d         = DONE;
            d_lo_d          = '0;
            d_hi_d          = '0;
            eflags_d        = bus.eflags_as_src;
            eflags_update_d = 1'b0;
            div_fault_d     = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = step_s;
        cnt_d = cnt_q + CW'(1);
        if (last_s) begin
          state_d     = DONE;
          div_fault_d = 1'b0;
          if (op_q[1]) begin
            d_lo_d          = (neg_res_q ? neg_w(step_s[W-1:0]) : step_s[W-1:0]) & mask_s;
            d_hi_d          = (neg_rem_q ? neg_w(step_s[2*W-1:W]) : step_s[2*W-1:W]) & mask_s;
            eflags_d        = eflags_src_q;
            eflags_update_d = 1'b0;
          end else begin
            d_lo_d          = mul_lo_s;
            d_hi_d          = mul_hi_s;
            eflags_d        = mul_flags_s;
            eflags_update_d = 1'b1;
          end
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset clears everything and drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      op_q            <= 2'd0;
      bmd_q           <= 2'd0;
      eflags_src_q    <= '0;
      a_q             <= '0;
      acc_q           <= '0;
      neg_res_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      d_lo_q          <= '0;
      d_hi_q          <= '0;
      eflags_q        <= '0;
      eflags_update_q <= 1'b0;
      div_fault_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      bmd_q           <= bmd_d;
      eflags_src_q    <= eflags_src_d;
      a_q             <= a_d;
      acc_q           <= acc_d;
      neg_res_q       <= neg_res_d;
      neg_rem_q       <= neg_rem_d;
      d_lo_q          <= d_lo_d;
      d_hi_q          <= d_hi_d;
      eflags_q        <= eflags_d;
      eflags_update_q <= eflags_update_d;
      div_fault_q     <= div_fault_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.d_lo          = d_lo_q;
  assign bus.d_hi          = d_hi_q;
  assign bus.eflags        = eflags_q;
  assign bus.eflags_update = eflags_update_q;
  assign bus.div_fault     = div_fault_q;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed plus randomized bench for iter_muldiv_unit against a plain-arithmetic reference model.
module tb_iter_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  iter_muldiv_if #(.W(64)) bus ();

  iter_muldiv_unit #(.W(64), .MUL_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: native wide multiply, SV division (truncating toward zero) and remainder.
  task automatic ref_model(input logic [1:0] op, input logic [1:0] bmd,
                           input logic [63:0] s, input logic [63:0] t, input logic [63:0] ef,
                           output logic [63:0] lo, output logic [63:0] hi,
                           output logic [63:0] fl, output logic upd, output logic flt);
    int           n;
    logic [63:0]  mask, su, tu, sx, tx;
    logic [127:0] p;
    longint       a, b, q, r, min_n;
    logic         cf;
    n    = 8 << bmd;
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    su   = s & mask;
    tu   = t & mask;
    sx   = su[n-1] ? (su | ~mask) : su;
    tx   = tu[n-1] ? (tu | ~mask) : tu;
    lo = 64'd0; hi = 64'd0; fl = ef; upd = 1'b0; flt = 1'b0;
    if (op[1] == 1'b0) begin
      if (op[0]) p = {{64{sx[63]}}, sx} * {{64{tx[63]}}, tx};
      else       p = {64'd0, su} * {64'd0, tu};
      lo  = p[63:0] & mask;
      hi  = 64'(p >> n) & mask;
      cf  = op[0] ? (hi != (lo[n-1] ? mask : 64'd0)) : (hi != 64'd0);
      fl[0] = cf; fl[11] = cf; fl[7] = lo[n-1]; fl[6] = (lo == 64'd0);
      fl[2] = ~^lo[7:0]; fl[4] = 1'b0;
      upd = 1'b1;
    end else if (op[0] == 1'b0) begin
      if (tu == 64'd0) flt = 1'b1;
      else begin lo = su / tu; hi = su % tu; end
    end else begin
      a = sx; b = tx;
      min_n = -(longint'(1) << (n - 1));
      if (b == 0 || (a == min_n && b == -1)) flt = 1'b1;
      else begin
        q = a / b; r = a % b;
        lo = q & mask; hi = r & mask;
      end
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [1:0] bmd, input logic [63:0] s,
                       input logic [63:0] t, input logic [63:0] ef, input int hold);
    logic [63:0] e_lo, e_hi, e_fl;
    logic        e_upd, e_flt;
    int          lat, e_lat;
    ref_model(op, bmd, s, t, ef, e_lo, e_hi, e_fl, e_upd, e_flt);
    e_lat = e_flt ? 1 : (op[1] ? 65 : 17);
    check("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1; bus.op = op; bus.bmd = bmd; bus.s = s; bus.t = t;
    bus.eflags_as_src = ef; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.s = {$urandom, $urandom}; bus.t = {$urandom, $urandom};
    bus.eflags_as_src = {$urandom, $urandom};
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(e_lat));
    check("d_lo", bus.d_lo, e_lo);
    check("d_hi", bus.d_hi, e_hi);
    check("eflags", bus.eflags, e_fl);
    check("eflags_update", {63'd0, bus.eflags_update}, {63'd0, e_upd});
    check("div_fault", {63'd0, bus.div_fault}, {63'd0, e_flt});
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.s = {$urandom, $urandom}; bus.t = {$urandom, $urandom};
      bus.op = 2'($urandom); bus.bmd = 2'($urandom);
      @(negedge clk);
    end
    if (hold > 0) begin
      check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("hold_d_lo", bus.d_lo, e_lo);
      check("hold_d_hi", bus.d_hi, e_hi);
      check("hold_eflags", bus.eflags, e_fl);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("handoff_out_valid", {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 2'd0; bus.bmd = 2'd0; bus.s = 64'd0; bus.t = 64'd0;
    bus.eflags_as_src = 64'd0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_d_lo", bus.d_lo, 64'd0);
    check("rst_d_hi", bus.d_hi, 64'd0);
    check("rst_eflags", bus.eflags, 64'd0);
    check("rst_upd", {63'd0, bus.eflags_update}, 64'd0);
    check("rst_fault", {63'd0, bus.div_fault}, 64'd0);

    do_op(2'd0, 2'd0, 64'h10, 64'h20, 64'h0000_0000_0000_0A55, 0);
    do_op(2'd1, 2'd2, 64'hFFFF_FFFF, 64'd5, 64'h0000_0000_0000_0202, 0);
    do_op(2'd3, 2'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h0000_0000_0000_08D5, 0);
    do_op(2'd2, 2'd1, 64'h1234, 64'hABCD_0000, 64'h0000_0000_0000_0046, 0);
    do_op(2'd3, 2'd0, 64'h80, 64'hFF, 64'h0000_0000_0000_0001, 0);
    do_op(2'd1, 2'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 10);
    do_op(2'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);

    // Reset mid-CALC discards the operation.
    bus.in_valid = 1'b1; bus.op = 2'd2; bus.bmd = 2'd3; bus.s = 64'd1000; bus.t = 64'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    do_op(2'd0, 2'd3, 64'd3, 64'd7, 64'd0, 0);
    check("mul_3x7", bus.d_lo, 64'd21);

    for (int k = 0; k < 30; k++) begin
      logic [63:0] rs, rt;
      rs = {$urandom, $urandom};
      rt = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rt = 64'd0;
      do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rs, rt,
            {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
